// File: rtl/ap1000_bp_reset_pkg.sv
// Shared definitions for the AP1000 board reset conditioner: FSM encodings,
// synchroniser depth and counter sizing.
package ap1000_bp_reset_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        S_DCM_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_RUN       = 3'd2,
        S_SOFT      = 3'd3,
        S_FAIL      = 3'd4
    } rst_state_t;

    // A counter only ever needs to reach terminal-1; keep at least one bit.
    function automatic int cnt_width(input int terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

// File: rtl/ap1000_bp_debounce.sv
// Push-button front end: 2-FF synchroniser, stability counter and a single
// pulse on the debounced press (1->0) edge.
module ap1000_bp_debounce
    import ap1000_bp_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic ref_clk,
    input  logic rst_n,
    input  logic rst_button_n,
    output logic btn_press
);

    localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] btn_sync;
    logic [DB_W-1:0]        stable_cnt;
    logic                   btn_s;
    logic                   btn_db;

    assign btn_s = btn_sync[SYNC_STAGES-1];

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync   <= '1;
            stable_cnt <= '0;
            btn_db     <= 1'b1;
            btn_press  <= 1'b0;
        end else begin
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], rst_button_n};
            btn_press <= 1'b0;
            if (btn_s == btn_db) begin
                stable_cnt <= '0;
            end else if (stable_cnt == DB_LAST) begin
                // Accept the new level; only a released->pressed change pulses.
                stable_cnt <= '0;
                btn_db     <= btn_s;
                btn_press  <= btn_db;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ap1000_bp_reset_conditioner.sv
// Board reset front end: synchronised power-on reset release, DCM reset/lock
// sequencing with bounded retries, push-button and software soft reset.
module ap1000_bp_reset_conditioner
    import ap1000_bp_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int DCM_RST_CYCLES  = 16,
    parameter int LOCK_TIMEOUT    = 1048576,
    parameter int MAX_RETRIES     = 7,
    parameter int SOFT_RST_CYCLES = 64
) (
    input  logic       ref_clk,
    input  logic       async_board_rst_n,
    input  logic       rst_button_n,
    input  logic       soft_rst_req,
    input  logic       plb_dcm_locked,
    input  logic       opb_dcm_locked,
    input  logic       ddr_fb_dcm_locked,
    output logic       dcm_rst,
    output logic       fpga_rst_n,
    output logic       lock_fail,
    output logic [2:0] retry_count
);

    localparam int DCM_W  = cnt_width(DCM_RST_CYCLES);
    localparam int LOCK_W = cnt_width(LOCK_TIMEOUT);
    localparam int SOFT_W = cnt_width(SOFT_RST_CYCLES);

    localparam logic [DCM_W-1:0]  DCM_LAST  = DCM_W'(DCM_RST_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);
    localparam logic [SOFT_W-1:0] SOFT_LAST = SOFT_W'(SOFT_RST_CYCLES - 1);

    logic [SYNC_STAGES-1:0] rst_sync;
    logic                   rst_n_int;
    logic [SYNC_STAGES-1:0] plb_sync, opb_sync, ddr_sync;
    logic                   all_locked;
    logic                   btn_press;
    logic                   retry_exhausted;

    rst_state_t        state, next_state;
    logic [DCM_W-1:0]  dcm_cnt;
    logic [LOCK_W-1:0] lock_tmr;
    logic [SOFT_W-1:0] soft_cnt;

    // Assert immediately, release only after SYNC_STAGES clean ref_clk edges.
    always_ff @(posedge ref_clk or negedge async_board_rst_n) begin
        if (!async_board_rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[SYNC_STAGES-1];

    always_ff @(posedge ref_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            plb_sync <= '0;
            opb_sync <= '0;
            ddr_sync <= '0;
        end else begin
            plb_sync <= {plb_sync[SYNC_STAGES-2:0], plb_dcm_locked};
            opb_sync <= {opb_sync[SYNC_STAGES-2:0], opb_dcm_locked};
            ddr_sync <= {ddr_sync[SYNC_STAGES-2:0], ddr_fb_dcm_locked};
        end
    end

    assign all_locked = plb_sync[SYNC_STAGES-1] & opb_sync[SYNC_STAGES-1]
                      & ddr_sync[SYNC_STAGES-1];

    ap1000_bp_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .ref_clk      (ref_clk),
        .rst_n        (rst_n_int),
        .rst_button_n (rst_button_n),
        .btn_press    (btn_press)
    );

    assign retry_exhausted = (int'(retry_count) + 1) >= MAX_RETRIES;

    always_comb begin
        next_state = state;
        case (state)
            S_DCM_RST: begin
                if (!btn_press && dcm_cnt == DCM_LAST) next_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (btn_press)                  next_state = S_DCM_RST;
                else if (all_locked)            next_state = S_RUN;
                else if (lock_tmr == LOCK_LAST) next_state = retry_exhausted ? S_FAIL : S_DCM_RST;
            end
            S_RUN: begin
                if (btn_press || !all_locked) next_state = S_DCM_RST;
                else if (soft_rst_req)        next_state = S_SOFT;
            end
            S_SOFT: begin
                if (btn_press || !all_locked)  next_state = S_DCM_RST;
                else if (soft_cnt == SOFT_LAST) next_state = S_RUN;
            end
            S_FAIL: begin
                if (btn_press) next_state = S_DCM_RST;
            end
            default: next_state = S_DCM_RST;
        endcase
    end

    // dcm_rst follows the state one cycle late so that it never moves on the
    // same edge as fpga_rst_n, which drops as soon as S_RUN is left.
    always_ff @(posedge ref_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state       <= S_DCM_RST;
            dcm_rst     <= 1'b1;
            fpga_rst_n  <= 1'b0;
            lock_fail   <= 1'b0;
            retry_count <= '0;
        end else begin
            state      <= next_state;
            dcm_rst    <= (state == S_DCM_RST);
            fpga_rst_n <= (next_state == S_RUN) && (state == S_RUN || state == S_SOFT);
            if (state == S_FAIL && btn_press) begin
                lock_fail   <= 1'b0;
                retry_count <= '0;
            end else if (state == S_WAIT_LOCK && !btn_press) begin
                if (all_locked) begin
                    retry_count <= '0;
                end else if (lock_tmr == LOCK_LAST) begin
                    if (retry_count != 3'd7) retry_count <= retry_count + 3'd1;
                    if (retry_exhausted)     lock_fail   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ref_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            dcm_cnt  <= '0;
            lock_tmr <= '0;
            soft_cnt <= '0;
        end else begin
            if (state != S_DCM_RST || btn_press) dcm_cnt <= '0;
            else if (dcm_cnt != DCM_LAST)        dcm_cnt <= dcm_cnt + 1'b1;

            if (state != S_WAIT_LOCK)      lock_tmr <= '0;
            else if (lock_tmr != LOCK_LAST) lock_tmr <= lock_tmr + 1'b1;

            if (state != S_SOFT)            soft_cnt <= '0;
            else if (soft_cnt != SOFT_LAST) soft_cnt <= soft_cnt + 1'b1;
        end
    end

endmodule
